keyboard_tracker: RTL and testbench

KEYBOARD_TRACKER -- requirements
Module: keyboard_tracker

---
 rtl/keyboard_tracker.sv | 139 +++++++++++++
 tb/tb_keyboard_tracker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_tracker.sv
`timescale 1ns / 1ps
// PS/2 keyboard receiver that tracks the S, Enter and Space keys.
// Outputs are active-low and are either held levels or one-clock press pulses.
module keyboard_tracker #(
  parameter bit PULSE_OR_HOLD = 1'b0,
  parameter int TIMEOUT       = 100000
) (
  input  logic clock,
  input  logic reset,
  inout  wire  PS2_CLK,
  inout  wire  PS2_DAT,
  output logic s,
  output logic enter,
  output logic space
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Handshake: byte_valid is a one-clock strobe, rx_byte is stable while it is high.
  // There is no back-pressure; the decoder consumes every strobe.
  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          ps2_fall;
  logic [3:0]    bit_cnt;
  logic [10:0]   shift_reg;
  logic [10:0]   frame_next;
  logic [TW-1:0] idle_cnt;
  logic          frame_ok;
  logic          byte_valid;
  logic [7:0]    rx_byte;

  logic          brk, ext;
  logic          brk_next, ext_next;
  logic [2:0]    held, held_next;
  logic [2:0]    key_low;

  // The PS/2 lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= PS2_CLK;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= PS2_DAT;
      dat_s2   <= dat_s1;
    end
  end

  assign ps2_fall   = clk_prev & ~clk_s2;
  assign frame_next = {dat_s2, shift_reg[10:1]};
  // Frame bits: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
  assign frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
    end else begin
      byte_valid <= 1'b0;
      if (ps2_fall) begin
        shift_reg <= frame_next;
        idle_cnt  <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt    <= '0;
          byte_valid <= frame_ok;
          rx_byte    <= frame_next[8:1];
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // A stalled partial frame is abandoned so the next start bit realigns.
        if (idle_cnt == TW'(TIMEOUT - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end

  // held index: 0 = s, 1 = enter, 2 = space
  always_comb begin
    held_next = held;
    brk_next  = brk;
    ext_next  = ext;
    if (byte_valid) begin
      if (rx_byte == 8'hF0) begin
        brk_next = 1'b1;
      end else if (rx_byte == 8'hE0) begin
        ext_next = 1'b1;
      end else begin
        brk_next = 1'b0;
        ext_next = 1'b0;
        if (!ext) begin
          case (rx_byte)
            8'h1B:   held_next[0] = ~brk;
            8'h5A:   held_next[1] = ~brk;
            8'h29:   held_next[2] = ~brk;
            default: ;
          endcase
        end
      end
    end
  end

  // Outputs are registered from held_next so they move one clock after byte_valid.
  always_comb begin
    if (PULSE_OR_HOLD) key_low = held_next;
    else               key_low = held_next & ~held;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      brk   <= 1'b0;
      ext   <= 1'b0;
      held  <= '0;
      s     <= 1'b1;
      enter <= 1'b1;
      space <= 1'b1;
    end else begin
      brk   <= brk_next;
      ext   <= ext_next;
      held  <= held_next;
      s     <= ~key_low[0];
      enter <= ~key_low[1];
      space <= ~key_low[2];
    end
  end

endmodule

// File: tb/tb_keyboard_tracker.sv
`timescale 1ns / 1ps
// Directed bench for keyboard_tracker: a hold-mode and a pulse-mode instance share one
// PS/2 stimulus stream, with a scaled-down bit period and timeout.
module tb_keyboard_tracker;

  localparam int TO = 200;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  wire  ps2_clk_w, ps2_dat_w;
  logic s_h, enter_h, space_h, s_p, enter_p, space_p;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int mk, bk;

  // index: 0 s_h, 1 enter_h, 2 space_h, 3 s_p, 4 enter_p, 5 space_p
  logic [5:0] outs, outs_prev;
  int low_cnt[6], fall_cnt[6], fall_at[6], rise_at[6];
  int base_low[6], base_fall[6];

  assign ps2_clk_w = ps2_clk;
  assign ps2_dat_w = ps2_dat;
  assign outs = {space_p, enter_p, s_p, space_h, enter_h, s_h};

  keyboard_tracker #(.PULSE_OR_HOLD(1'b1), .TIMEOUT(TO)) dut_hold (
    .clock(clock), .reset(reset), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
    .s(s_h), .enter(enter_h), .space(space_h)
  );

  keyboard_tracker #(.PULSE_OR_HOLD(1'b0), .TIMEOUT(TO)) dut_pulse (
    .clock(clock), .reset(reset), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
    .s(s_p), .enter(enter_p), .space(space_p)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 6; i++) begin
      low_cnt[i] = 0; fall_cnt[i] = 0; fall_at[i] = 0; rise_at[i] = 0;
    end
    outs_prev = 6'h3F;
  end

  always @(negedge clock) begin
    for (int i = 0; i < 6; i++) begin
      if (outs[i] === 1'b0) low_cnt[i]++;
      if (outs_prev[i] === 1'b1 && outs[i] === 1'b0) begin
        fall_cnt[i]++;
        fall_at[i] = cyc;
      end
      if (outs_prev[i] === 1'b0 && outs[i] === 1'b1) rise_at[i] = cyc;
    end
    outs_prev = outs;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic send_bit(input logic b);
    ps2_dat = b;
    repeat (5) @(negedge clock);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (10) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_flip,
                            input logic start_v, input logic stop_v);
    logic [10:0] f;
    f = {stop_v, (~^data) ^ par_flip, data, start_v};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2_dat = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic send_ok(input logic [7:0] data);
    send_frame(data, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic snap();
    for (int i = 0; i < 6; i++) begin
      base_low[i]  = low_cnt[i];
      base_fall[i] = fall_cnt[i];
    end
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (outs !== 6'h3F) begin errors++; $display("FAIL reset_outputs: got %b expected 111111", outs); end
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    checks++; if (outs !== 6'h3F) begin errors++; $display("FAIL post_reset_idle: got %b expected 111111", outs); end
  endtask

  task automatic test_hold_make_break();
    snap();
    send_ok(8'h1B);
    mk = last_fall_cyc;
    checks++; if (s_h !== 1'b0) begin errors++; $display("FAIL hold_s_make: got %b expected 0", s_h); end
    checks++; if (fall_at[0] - mk !== 4) begin errors++; $display("FAIL hold_s_make_latency: got %0d expected 4", fall_at[0] - mk); end
    checks++; if (fall_at[3] - mk !== 4) begin errors++; $display("FAIL pulse_s_latency: got %0d expected 4", fall_at[3] - mk); end
    checks++; if (low_cnt[3] - base_low[3] !== 1) begin errors++; $display("FAIL pulse_s_width: got %0d expected 1", low_cnt[3] - base_low[3]); end
    send_ok(8'hF0);
    checks++; if (s_h !== 1'b0) begin errors++; $display("FAIL hold_s_after_f0: got %b expected 0", s_h); end
    send_ok(8'h1B);
    bk = last_fall_cyc;
    checks++; if (s_h !== 1'b1) begin errors++; $display("FAIL hold_s_break: got %b expected 1", s_h); end
    checks++; if (rise_at[0] - bk !== 4) begin errors++; $display("FAIL hold_s_break_latency: got %0d expected 4", rise_at[0] - bk); end
    checks++; if (low_cnt[0] - base_low[0] !== rise_at[0] - fall_at[0]) begin errors++; $display("FAIL hold_s_low_span: got %0d expected %0d", low_cnt[0] - base_low[0], rise_at[0] - fall_at[0]); end
    checks++; if (low_cnt[1] - base_low[1] !== 0 || low_cnt[2] - base_low[2] !== 0) begin errors++; $display("FAIL hold_others_quiet: got enter %0d space %0d expected 0 0", low_cnt[1] - base_low[1], low_cnt[2] - base_low[2]); end
    checks++; if (low_cnt[3] - base_low[3] !== 1) begin errors++; $display("FAIL pulse_s_no_break_pulse: got %0d expected 1", low_cnt[3] - base_low[3]); end
  endtask

  task automatic test_pulse_typematic();
    snap();
    send_ok(8'h5A);
    send_ok(8'h5A);
    send_ok(8'h5A);
    send_ok(8'hF0);
    send_ok(8'h5A);
    send_ok(8'h5A);
    checks++; if (low_cnt[4] - base_low[4] !== 2) begin errors++; $display("FAIL pulse_enter_low_cycles: got %0d expected 2", low_cnt[4] - base_low[4]); end
    checks++; if (fall_cnt[4] - base_fall[4] !== 2) begin errors++; $display("FAIL pulse_enter_pulses: got %0d expected 2", fall_cnt[4] - base_fall[4]); end
    checks++; if (fall_cnt[1] - base_fall[1] !== 2 || enter_h !== 1'b0) begin errors++; $display("FAIL hold_enter_typematic: got falls %0d level %b expected 2 0", fall_cnt[1] - base_fall[1], enter_h); end
    send_ok(8'hF0);
    send_ok(8'h5A);
    checks++; if (enter_h !== 1'b1 || enter_p !== 1'b1) begin errors++; $display("FAIL enter_release: got %b%b expected 11", enter_h, enter_p); end
  endtask

  task automatic test_bad_parity();
    snap();
    send_frame(8'h29, 1'b1, 1'b0, 1'b1);
    checks++; if (space_h !== 1'b1 || low_cnt[5] - base_low[5] !== 0) begin errors++; $display("FAIL bad_parity_ignored: got level %b pulses %0d expected 1 0", space_h, low_cnt[5] - base_low[5]); end
    send_ok(8'h29);
    checks++; if (space_h !== 1'b0) begin errors++; $display("FAIL space_after_good: got %b expected 0", space_h); end
    checks++; if (fall_cnt[5] - base_fall[5] !== 1) begin errors++; $display("FAIL space_pulse_after_good: got %0d expected 1", fall_cnt[5] - base_fall[5]); end
  endtask

  task automatic test_bad_frame();
    send_ok(8'hF0);
    send_frame(8'h29, 1'b1, 1'b0, 1'b1);
    checks++; if (space_h !== 1'b0) begin errors++; $display("FAIL bad_frame_keeps_space: got %b expected 0", space_h); end
    send_ok(8'h29);
    checks++; if (space_h !== 1'b1) begin errors++; $display("FAIL break_flag_survives_drop: got %b expected 1", space_h); end
    snap();
    send_frame(8'h1B, 1'b0, 1'b1, 1'b1);
    send_frame(8'h1B, 1'b0, 1'b0, 1'b0);
    checks++; if (s_h !== 1'b1 || low_cnt[3] - base_low[3] !== 0) begin errors++; $display("FAIL bad_start_stop_ignored: got level %b pulses %0d expected 1 0", s_h, low_cnt[3] - base_low[3]); end
  endtask

  task automatic test_timeout();
    logic [4:0] part;
    snap();
    part = {4'b1011 ^ 4'b0000, 1'b0};
    for (int i = 0; i < 5; i++) send_bit(part[i]);
    ps2_dat = 1'b1;
    repeat (2 * TO) @(negedge clock);
    send_ok(8'h1B);
    checks++; if (s_h !== 1'b0) begin errors++; $display("FAIL timeout_recovery_hold: got %b expected 0", s_h); end
    checks++; if (fall_cnt[3] - base_fall[3] !== 1) begin errors++; $display("FAIL timeout_recovery_pulse: got %0d expected 1", fall_cnt[3] - base_fall[3]); end
    send_ok(8'hF0);
    send_ok(8'h1B);
    checks++; if (s_h !== 1'b1) begin errors++; $display("FAIL timeout_release: got %b expected 1", s_h); end
  endtask

  task automatic test_extended();
    snap();
    send_ok(8'hE0);
    send_ok(8'h5A);
    checks++; if (enter_h !== 1'b1 || low_cnt[1] - base_low[1] !== 0) begin errors++; $display("FAIL keypad_enter_ignored: got level %b lows %0d expected 1 0", enter_h, low_cnt[1] - base_low[1]); end
    checks++; if (low_cnt[4] - base_low[4] !== 0) begin errors++; $display("FAIL keypad_enter_no_pulse: got %0d expected 0", low_cnt[4] - base_low[4]); end
    send_ok(8'h29);
    send_ok(8'h1B);
    checks++; if ({space_h, s_h, enter_h} !== 3'b001) begin errors++; $display("FAIL multi_key_hold: got %b expected 001", {space_h, s_h, enter_h}); end
  endtask

  task automatic test_reset_mid_hold();
    checks++; if (s_h !== 1'b0) begin errors++; $display("FAIL pre_reset_s_held: got %b expected 0", s_h); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if ({s_h, space_h, s_p} !== 3'b111) begin errors++; $display("FAIL async_reset_outputs: got %b expected 111", {s_h, space_h, s_p}); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    snap();
    send_ok(8'hF0);
    send_ok(8'h1B);
    checks++; if (s_h !== 1'b1 || low_cnt[0] - base_low[0] !== 0) begin errors++; $display("FAIL break_after_reset: got level %b lows %0d expected 1 0", s_h, low_cnt[0] - base_low[0]); end
    send_ok(8'h29);
    checks++; if (space_h !== 1'b0 || fall_cnt[5] - base_fall[5] !== 1) begin errors++; $display("FAIL held_cleared_by_reset: got level %b pulses %0d expected 0 1", space_h, fall_cnt[5] - base_fall[5]); end
  endtask

  initial begin
    test_reset();
    test_hold_make_break();
    test_pulse_typematic();
    test_bad_parity();
    test_bad_frame();
    test_timeout();
    test_extended();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
